// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - settings defaults, steps, clamps and key index names for key_ctrl
package key_ctrl_pkg;
  localparam int PHASE_W  = 24;
  localparam int NUM_KEYS = 8;

  localparam logic [PHASE_W-1:0] FREQ_DEFAULT = 24'd1678;
  localparam logic [PHASE_W-1:0] FREQ_STEP    = 24'd1678;
  localparam logic [PHASE_W-1:0] FREQ_STEP_C  = FREQ_STEP << 4;
  localparam logic [PHASE_W-1:0] FREQ_MIN     = 24'd1678;
  localparam logic [PHASE_W-1:0] FREQ_MAX     = 24'h300000;

  localparam logic signed [11:0] M_DEFAULT = 12'sd1024;
  localparam logic signed [11:0] M_STEP    = 12'sd204;
  localparam logic signed [11:0] M_MAX     = 12'sd1844;

  localparam int KEY_DEF    = 0;
  localparam int KEY_FUP    = 1;
  localparam int KEY_FDN    = 2;
  localparam int KEY_FUP_C  = 3;
  localparam int KEY_FDN_C  = 4;
  localparam int KEY_MUP    = 5;
  localparam int KEY_MDN    = 6;
  localparam int KEY_WAVE   = 7;
endpackage

// File: rtl/key_ctrl_if.sv
// rtl/key_ctrl_if.sv - key_ctrl output bundle: press pulses, run-time settings and update strobe
interface key_ctrl_if;
  import key_ctrl_pkg::*;

  logic [NUM_KEYS-1:0] key_pulse;
  logic [PHASE_W-1:0]  freq_word;
  logic signed [11:0]  m0;
  logic [1:0]          wave_sel;
  logic                upd;

  modport master (output key_pulse, freq_word, m0, wave_sel, upd);
  modport slave  (input  key_pulse, freq_word, m0, wave_sel, upd);
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: 2-FF synchroniser, debounce counter, stable level, press pulse
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_pulse
);
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_key;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
      // Any return to the accepted level restarts qualification from zero.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/key_ctrl.sv
// rtl/key_ctrl.sv - debounces eight front-panel keys and owns freq_word, m0 and wave_sel
module key_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key0,
  input  logic              i_key1,
  input  logic              i_key2,
  input  logic              i_key3,
  input  logic              i_key4,
  input  logic              i_key5,
  input  logic              i_key6,
  input  logic              i_key7,
  key_ctrl_if.master        o_ctrl
);
  logic [NUM_KEYS-1:0] w_keys;
  logic [NUM_KEYS-1:0] w_pulse;

  assign w_keys = {i_key7, i_key6, i_key5, i_key4, i_key3, i_key2, i_key1, i_key0};

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key   (w_keys[gi]),
      .o_pulse (w_pulse[gi])
    );
  end

  logic [PHASE_W-1:0] r_freq;
  logic signed [11:0] r_m0;
  logic [1:0]         r_wave;
  logic               r_upd;

  logic [PHASE_W:0]   w_up_amt;
  logic [PHASE_W:0]   w_dn_amt;
  logic [PHASE_W:0]   w_fsum;
  logic [PHASE_W:0]   w_fdiff;
  logic [PHASE_W-1:0] w_freq_nxt;

  // One extra bit so the sum cannot wrap and a borrow shows up in the MSB.
  always_comb begin
    w_up_amt = '0;
    w_dn_amt = '0;
    if (w_pulse[KEY_FUP])   w_up_amt = w_up_amt + {1'b0, FREQ_STEP};
    if (w_pulse[KEY_FUP_C]) w_up_amt = w_up_amt + {1'b0, FREQ_STEP_C};
    if (w_pulse[KEY_FDN])   w_dn_amt = w_dn_amt + {1'b0, FREQ_STEP};
    if (w_pulse[KEY_FDN_C]) w_dn_amt = w_dn_amt + {1'b0, FREQ_STEP_C};
    w_fsum     = {1'b0, r_freq} + w_up_amt;
    w_fdiff    = {1'b0, r_freq} - w_dn_amt;
    w_freq_nxt = r_freq;
    if (w_up_amt != '0 && w_dn_amt == '0) begin
      w_freq_nxt = (w_fsum > {1'b0, FREQ_MAX}) ? FREQ_MAX : w_fsum[PHASE_W-1:0];
    end else if (w_dn_amt != '0 && w_up_amt == '0) begin
      w_freq_nxt = (w_fdiff[PHASE_W] || (w_fdiff < {1'b0, FREQ_MIN})) ? FREQ_MIN
                                                                       : w_fdiff[PHASE_W-1:0];
    end
  end

  localparam logic signed [12:0] M_STEP_X = 13'(M_STEP);
  localparam logic signed [12:0] M_MAX_X  = 13'(M_MAX);

  logic signed [12:0] w_mdelta;
  logic signed [12:0] w_msum;
  logic signed [11:0] w_m0_nxt;

  always_comb begin
    w_mdelta = '0;
    if (w_pulse[KEY_MUP] && !w_pulse[KEY_MDN]) w_mdelta = M_STEP_X;
    if (w_pulse[KEY_MDN] && !w_pulse[KEY_MUP]) w_mdelta = -M_STEP_X;
    w_msum = 13'(r_m0) + w_mdelta;
    if (w_msum > M_MAX_X)       w_m0_nxt = M_MAX;
    else if (w_msum < -M_MAX_X) w_m0_nxt = -M_MAX;
    else                        w_m0_nxt = w_msum[11:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_freq <= FREQ_DEFAULT;
      r_m0   <= M_DEFAULT;
      r_wave <= 2'd0;
      r_upd  <= 1'b0;
    end else begin
      r_upd <= |w_pulse;
      if (w_pulse[KEY_DEF]) begin
        r_freq <= FREQ_DEFAULT;
        r_m0   <= M_DEFAULT;
        r_wave <= 2'd0;
      end else begin
        r_freq <= w_freq_nxt;
        r_m0   <= w_m0_nxt;
        r_wave <= r_wave + {1'b0, w_pulse[KEY_WAVE]};
      end
    end
  end

  assign o_ctrl.key_pulse = w_pulse;
  assign o_ctrl.freq_word = r_freq;
  assign o_ctrl.m0        = r_m0;
  assign o_ctrl.wave_sel  = r_wave;
  assign o_ctrl.upd       = r_upd;
endmodule
